// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, T-states and
// the bit layout of the packed control word.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_e;

  localparam int unsigned CTRL_W = 14;
  typedef logic [CTRL_W-1:0] ctrl_word_t;

  localparam int unsigned CW_PC_OUT  = 0;
  localparam int unsigned CW_PC_INC  = 1;
  localparam int unsigned CW_PC_JUMP = 2;
  localparam int unsigned CW_MAR_IN  = 3;
  localparam int unsigned CW_RAM_IN  = 4;
  localparam int unsigned CW_RAM_OUT = 5;
  localparam int unsigned CW_IR_IN   = 6;
  localparam int unsigned CW_IR_OUT  = 7;
  localparam int unsigned CW_A_IN    = 8;
  localparam int unsigned CW_A_OUT   = 9;
  localparam int unsigned CW_B_IN    = 10;
  localparam int unsigned CW_ALU_OUT = 11;
  localparam int unsigned CW_ALU_SUB = 12;
  localparam int unsigned CW_O_IN    = 13;

  // One-hot control word with a single bit set.
  function automatic ctrl_word_t cw(input int unsigned idx);
    return ctrl_word_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word, plus the
// sequencing hints the top level needs (last step, halt, flag capture).
module sap_microcode_rom
  import sap_pkg::*;
(
  input  logic [3:0] opcode,
  input  t_state_e   step,
  input  logic       flag_c,
  input  logic       flag_z,
  output ctrl_word_t ctrl,
  output logic       last_step,
  output logic       halt_step,
  output logic       flag_load
);

  t_state_e last_t;

  // Decode the control word for the current step and the opcode's final step.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl      = '0;
    last_t    = T1;
    halt_step = 1'b0;
    flag_load = 1'b0;

    // Final active step per opcode; unlisted opcodes behave as NOP.
    case (opcode)
      OP_LDA, OP_STA:                       last_t = T3;
      OP_ADD, OP_SUB:                       last_t = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ,
      OP_OUT, OP_HLT:                       last_t = T2;
      default:                              last_t = T1;
    endcase

    if (step == T0) begin
      ctrl = cw(CW_PC_OUT) | cw(CW_MAR_IN);
    end else if (step == T1) begin
      ctrl = cw(CW_RAM_OUT) | cw(CW_IR_IN) | cw(CW_PC_INC);
    end else begin
      case (opcode)
        OP_LDA: begin
          if (step == T2) ctrl = cw(CW_IR_OUT) | cw(CW_MAR_IN);
          if (step == T3) ctrl = cw(CW_RAM_OUT) | cw(CW_A_IN);
        end
        OP_ADD, OP_SUB: begin
          if (step == T2) ctrl = cw(CW_IR_OUT) | cw(CW_MAR_IN);
          if (step == T3) ctrl = cw(CW_RAM_OUT) | cw(CW_B_IN);
          if (step == T4) ctrl = cw(CW_ALU_OUT) | cw(CW_A_IN);
          // Subtract select is held through both the B load and the result step.
          if (opcode == OP_SUB && step != T2) ctrl = ctrl | cw(CW_ALU_SUB);
          flag_load = (step == T4);
        end
        OP_STA: begin
          if (step == T2) ctrl = cw(CW_IR_OUT) | cw(CW_MAR_IN);
          if (step == T3) ctrl = cw(CW_A_OUT) | cw(CW_RAM_IN);
        end
        OP_LDI: if (step == T2) ctrl = cw(CW_IR_OUT) | cw(CW_A_IN);
        OP_JMP: if (step == T2) ctrl = cw(CW_IR_OUT) | cw(CW_PC_JUMP);
        OP_JC:  if (step == T2 && flag_c) ctrl = cw(CW_IR_OUT) | cw(CW_PC_JUMP);
        OP_JZ:  if (step == T2 && flag_z) ctrl = cw(CW_IR_OUT) | cw(CW_PC_JUMP);
        OP_OUT: if (step == T2) ctrl = cw(CW_A_OUT) | cw(CW_O_IN);
        OP_HLT: halt_step = (step == T2);
        default: ctrl = '0;
      endcase
    end

    last_step = (step == last_t);
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: T-state counter, C/Z flag register, halt latch and
// run/halt gating around the microcode ROM.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter bit EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] instruction,
  input  logic       alu_c,
  input  logic       alu_z,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       o_in,
  output logic       halted,
  output logic [2:0] t_state,
  output logic [1:0] flags
);

  t_state_e   state_q, state_d;
  logic [1:0] flags_q, flags_d;
  logic       halted_q, halted_d;
  ctrl_word_t ctrl_raw, ctrl;
  logic       last_step, halt_step, flag_load;
  logic       active;

  sap_microcode_rom u_rom (
    .opcode    (instruction),
    .step      (state_q),
    .flag_c    (flags_q[1]),
    .flag_z    (flags_q[0]),
    .ctrl      (ctrl_raw),
    .last_step (last_step),
    .halt_step (halt_step),
    .flag_load (flag_load)
  );

  assign active = run & ~halted_q;

  // Sequencer state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (reset) begin
      state_q  <= T0;
      flags_q  <= 2'b00;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  // Next step, flag capture and halt latch; everything holds when inactive.
  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    if (active) begin
      if (halt_step) begin
        halted_d = 1'b1;
      end else if ((EARLY_END && last_step) || state_q == T4) begin
        state_d = T0;
      end else begin
        state_d = t_state_e'(state_q + 3'd1);
      end
      if (flag_load) flags_d = {alu_c, alu_z};
    end
  end

  // Controls are silenced while stopped, halted or held in reset.
  assign ctrl = (active && !reset) ? ctrl_raw : '0;

  assign pc_out  = ctrl[CW_PC_OUT];
  assign pc_inc  = ctrl[CW_PC_INC];
  assign pc_jump = ctrl[CW_PC_JUMP];
  assign mar_in  = ctrl[CW_MAR_IN];
  assign ram_in  = ctrl[CW_RAM_IN];
  assign ram_out = ctrl[CW_RAM_OUT];
  assign ir_in   = ctrl[CW_IR_IN];
  assign ir_out  = ctrl[CW_IR_OUT];
  assign a_in    = ctrl[CW_A_IN];
  assign a_out   = ctrl[CW_A_OUT];
  assign b_in    = ctrl[CW_B_IN];
  assign alu_out = ctrl[CW_ALU_OUT];
  assign alu_sub = ctrl[CW_ALU_SUB];
  assign o_in    = ctrl[CW_O_IN];

  assign halted  = halted_q;
  assign t_state = state_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: one instance with EARLY_END=1
// and one with EARLY_END=0 share the stimulus; a reference model pushes the
// expected outputs per cycle and a monitor compares them mid-cycle.
module tb_sap_control_sequencer;

  typedef struct packed {
    logic pc_out, pc_inc, pc_jump, mar_in, ram_in, ram_out, ir_in;
    logic ir_out, a_in, a_out, b_in, alu_out, alu_sub, o_in;
  } ctrl_t;

  typedef struct packed {
    logic       d;
    ctrl_t      c;
    logic [2:0] t;
    logic [1:0] f;
    logic       h;
  } exp_t;

  logic       clk, rst, run, alu_c, alu_z;
  logic [3:0] instr;

  ctrl_t      ctl [2];
  logic [2:0] ts  [2];
  logic [1:0] fl  [2];
  logic       hl  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pc_out, pc_inc, pc_jump, mar_in, ram_in, ram_out, ir_in;
    logic ir_out, a_in, a_out, b_in, alu_out, alu_sub, o_in, halted;
    logic [2:0] t_state;
    logic [1:0] flags;

    sap_control_sequencer #(.EARLY_END(g == 0 ? 1'b1 : 1'b0)) dut (
      .clk(clk), .reset(rst), .run(run), .instruction(instr),
      .alu_c(alu_c), .alu_z(alu_z),
      .pc_out(pc_out), .pc_inc(pc_inc), .pc_jump(pc_jump),
      .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out),
      .ir_in(ir_in), .ir_out(ir_out), .a_in(a_in), .a_out(a_out),
      .b_in(b_in), .alu_out(alu_out), .alu_sub(alu_sub), .o_in(o_in),
      .halted(halted), .t_state(t_state), .flags(flags)
    );

    assign ctl[g] = {pc_out, pc_inc, pc_jump, mar_in, ram_in, ram_out, ir_in,
                     ir_out, a_in, a_out, b_in, alu_out, alu_sub, o_in};
    assign ts[g]  = t_state;
    assign fl[g]  = flags;
    assign hl[g]  = halted;
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model state, one per instance.
  int         mk [2];
  logic [1:0] mf [2];
  bit         mh [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole micro-program of an instruction as a list of steps; returns step k
  // and the number of steps up to and including the last active one.
  function automatic ctrl_t prog_step(input logic [3:0] op, input int k,
                                      input logic [1:0] f, output int len);
    ctrl_t p [5];
    for (int i = 0; i < 5; i++) p[i] = '0;
    p[0].pc_out = 1; p[0].mar_in = 1;
    p[1].ram_out = 1; p[1].ir_in = 1; p[1].pc_inc = 1;
    len = 2;
    case (op)
      4'h1: begin
        p[2].ir_out = 1; p[2].mar_in = 1; p[3].ram_out = 1; p[3].a_in = 1; len = 4;
      end
      4'h2, 4'h3: begin
        p[2].ir_out = 1; p[2].mar_in = 1;
        p[3].ram_out = 1; p[3].b_in = 1; p[3].alu_sub = (op == 4'h3);
        p[4].alu_out = 1; p[4].a_in = 1; p[4].alu_sub = (op == 4'h3);
        len = 5;
      end
      4'h4: begin
        p[2].ir_out = 1; p[2].mar_in = 1; p[3].a_out = 1; p[3].ram_in = 1; len = 4;
      end
      4'h5: begin p[2].ir_out = 1; p[2].a_in = 1; len = 3; end
      4'h6: begin p[2].ir_out = 1; p[2].pc_jump = 1; len = 3; end
      4'h7: begin p[2].ir_out = f[1]; p[2].pc_jump = f[1]; len = 3; end
      4'h8: begin p[2].ir_out = f[0]; p[2].pc_jump = f[0]; len = 3; end
      4'hE: begin p[2].a_out = 1; p[2].o_in = 1; len = 3; end
      4'hF: len = 3;
      default: len = 2;
    endcase
    return p[k];
  endfunction

  // Push this cycle's expected outputs, then advance the model to the next edge.
  task automatic model_cycle(input int d, input bit ee);
    exp_t  e;
    ctrl_t c;
    int    len;
    e.d = (d == 1);
    if (rst) begin
      mk[d] = 0; mf[d] = 2'b00; mh[d] = 1'b0;
      e.c = '0; e.t = 3'd0; e.f = 2'b00; e.h = 1'b0;
      sb.push_back(e);
      return;
    end
    c   = prog_step(instr, mk[d], mf[d], len);
    e.c = (run && !mh[d]) ? c : '0;
    e.t = 3'(mk[d]);
    e.f = mf[d];
    e.h = mh[d];
    sb.push_back(e);
    if (run && !mh[d]) begin
      if (instr == 4'hF && mk[d] == 2) begin
        mh[d] = 1'b1;
      end else begin
        if ((instr == 4'h2 || instr == 4'h3) && mk[d] == 4) mf[d] = {alu_c, alu_z};
        mk[d] = ((ee && mk[d] == len - 1) || mk[d] == 4) ? 0 : mk[d] + 1;
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_cycle(0, 1'b1);
      model_cycle(1, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare everything the model expects for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("d%0d_ctrl", e.d),   32'(ctl[e.d]), 32'(e.c));
        check($sformatf("d%0d_tstate", e.d), 32'(ts[e.d]),  32'(e.t));
        check($sformatf("d%0d_flags", e.d),  32'(fl[e.d]),  32'(e.f));
        check($sformatf("d%0d_halted", e.d), 32'(hl[e.d]),  32'(e.h));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; instr = 4'h0; alu_c = 1'b0; alu_z = 1'b0;
    @(posedge clk);
    #1;
    step(2);

    // NOP loop: 0,1,0,1 on the early-end instance.
    rst = 1'b0; run = 1'b1;
    step(4);

    // ADD with carry set -> flags 10.
    instr = 4'h2; alu_c = 1'b1; alu_z = 1'b0;
    step(5);

    // SUB with zero set -> flags 01, then JZ taken and JC not taken.
    instr = 4'h3; alu_c = 1'b0; alu_z = 1'b1;
    step(5);
    instr = 4'h8;
    step(3);
    instr = 4'h7;
    step(3);

    // LDA interrupted by asynchronous reset in T3.
    instr = 4'h1;
    step(3);
    rst = 1'b1;
    #1;
    check("async_rst_tstate", 32'(ts[0]), 32'd0);
    check("async_rst_ctrl", 32'(ctl[0]), 32'd0);
    step(1);
    rst = 1'b0;

    // ADD frozen at T3 for five clocks, then resumed.
    instr = 4'h2; alu_c = 1'b0; alu_z = 1'b0;
    step(3);
    run = 1'b0;
    step(5);
    run = 1'b1;
    step(2);

    // HLT, ten idle clocks, then reset clears it.
    instr = 4'hF;
    step(13);
    rst = 1'b1;
    step(1);
    rst = 1'b0;

    // LDI: the EARLY_END=0 instance walks 0..4 and wraps.
    instr = 4'h5;
    step(6);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 29) == 0);
      run   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) instr = 4'($urandom_range(0, 15));
      alu_c = 1'($urandom_range(0, 1));
      alu_z = 1'($urandom_range(0, 1));
      step(1);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
